// File: rtl/cdu_if_pkg.sv
// cdu_if_pkg: shared types and constants for the CDU pulse counter interface.
// Optional statistics outputs in the design are enabled with CDU_PULSE_STATS_EN.
package cdu_if_pkg;

    // Handshake FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } cdu_state_e;

    // Increment direction as seen on inc_dir_o
    localparam logic DIR_PINC = 1'b0;
    localparam logic DIR_MINC = 1'b1;

    // Default widths
    localparam int CDU_COUNT_W   = 15;
    localparam int CDU_BACKLOG_W = 6;

    // Largest magnitude a signed backlog of width w may hold (symmetric range)
    function automatic int backlog_sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/cdu_pulse_filter.sv
// cdu_pulse_filter: two-flop synchroniser plus run-length glitch filter for one
// CDU pulse line. edge_o fires once per high run that lasts MIN_PULSE_CYCLES
// synchronised cycles. With CDU_PULSE_STATS_EN defined, runt_o flags each high
// run that ended before reaching that length.
module cdu_pulse_filter
    import cdu_if_pkg::*;
#(
    parameter int MIN_PULSE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_i,
`ifdef CDU_PULSE_STATS_EN
    output logic runt_o,
`endif
    output logic edge_o
);

    localparam int                RUN_W   = 4;
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MIN_PULSE_CYCLES);
    localparam logic [RUN_W-1:0]  RUN_HIT = RUN_W'(MIN_PULSE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [RUN_W-1:0] run_reg;
    logic             edge_reg;

    // Synchronise, count the current high run (saturating so a held level
    // fires only once) and register the accepted edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            run_reg   <= '0;
            edge_reg  <= 1'b0;
        end else begin
            sync1_reg <= pulse_i;
            sync2_reg <= sync1_reg;
            if (!sync2_reg) begin
                run_reg <= '0;
            end else if (run_reg != RUN_MAX) begin
                run_reg <= run_reg + RUN_W'(1);
            end
            edge_reg <= sync2_reg && (run_reg == RUN_HIT);
        end
    end

    assign edge_o = edge_reg;

`ifdef CDU_PULSE_STATS_EN
    logic runt_reg;

    // In the first low cycle run_reg still holds the length of the run that
    // just ended; a nonzero length short of the threshold is a runt.
    always_ff @(posedge clk) begin
        if (rst) begin
            runt_reg <= 1'b0;
        end else begin
            runt_reg <= !sync2_reg && (run_reg != '0) && (run_reg < RUN_MAX);
        end
    end

    assign runt_o = runt_reg;
`endif

endmodule

// File: rtl/cdu_pulse_counter_if.sv
// cdu_pulse_counter_if: AGC-side consumer of the CDU ATpPGH/ATmPGH pulses.
// Filters both pulse lines, nets accepted edges into a saturating signed
// backlog and drains it one count per req/ack handshake into the angle counter.
// Define CDU_PULSE_STATS_EN to add the plus/minus/runt event totals.
module cdu_pulse_counter_if
    import cdu_if_pkg::*;
#(
    parameter int MIN_PULSE_CYCLES = 2,
    parameter int BACKLOG_W        = CDU_BACKLOG_W,
    parameter int COUNT_W          = CDU_COUNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 plus_pulse_i,
    input  logic                 minus_pulse_i,
    input  logic                 zero_i,
    input  logic                 inc_ack_i,
    output logic                 inc_req_o,
    output logic                 inc_dir_o,
    output logic [COUNT_W-1:0]   count_o,
    output logic [BACKLOG_W-1:0] backlog_o,
    output logic                 overflow_o,
`ifdef CDU_PULSE_STATS_EN
    output logic [15:0]          plus_total_o,
    output logic [15:0]          minus_total_o,
    output logic [15:0]          runt_total_o,
`endif
    input  logic                 clear_ovf_i
);

    // Two guard bits cover +1 plus one ack step beyond the saturation limit
    localparam int                       SUM_W     = BACKLOG_W + 2;
    localparam logic signed [SUM_W-1:0]  SAT_MAX   = SUM_W'(backlog_sat_max(BACKLOG_W));
    localparam logic signed [SUM_W-1:0]  SAT_MIN   = -SAT_MAX;
    localparam logic signed [SUM_W-1:0]  SUM_ONE   = SUM_W'(1);
    localparam logic [COUNT_W-1:0]       COUNT_ONE = COUNT_W'(1);

    // Index 0 carries the plus line, index 1 the minus line
    logic [1:0] pulse_vec;
    logic [1:0] edge_vec;
`ifdef CDU_PULSE_STATS_EN
    logic [1:0] runt_vec;
`endif

    assign pulse_vec = {minus_pulse_i, plus_pulse_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filter
            cdu_pulse_filter #(
                .MIN_PULSE_CYCLES (MIN_PULSE_CYCLES)
            ) u_filter (
                .clk     (clk),
                .rst     (rst),
                .pulse_i (pulse_vec[gi]),
`ifdef CDU_PULSE_STATS_EN
                .runt_o  (runt_vec[gi]),
`endif
                .edge_o  (edge_vec[gi])
            );
        end
    endgenerate

    cdu_state_e                  state_reg,   state_next;
    logic                        dir_reg,     dir_next;
    logic signed [BACKLOG_W-1:0] backlog_reg, backlog_next;
    logic [COUNT_W-1:0]          count_reg,   count_next;
    logic                        ovf_reg,     ovf_next;

    logic                        ack_accept;
    logic signed [SUM_W-1:0]     backlog_sum;
    logic                        sat_hit;

    // An ack only counts while a request is actually outstanding
    assign ack_accept = (state_reg == REQ) && inc_ack_i;

    // Handshake next state; direction is latched only when leaving IDLE so it
    // never changes under a pending request. zero_i aborts into GAP.
    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        case (state_reg)
            IDLE: begin
                if (backlog_reg != '0) begin
                    state_next = REQ;
                    dir_next   = backlog_reg[BACKLOG_W-1] ? DIR_MINC : DIR_PINC;
                end
            end
            REQ: begin
                if (inc_ack_i) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (zero_i) begin
            state_next = GAP;
            dir_next   = dir_reg;
        end
    end

    // Backlog/count/overflow next values: net the edges and the serviced step
    // in a widened sum, then clamp symmetrically; any clamp loses a count.
    always_comb begin
        backlog_sum  = $signed({{2{backlog_reg[BACKLOG_W-1]}}, backlog_reg});
        backlog_next = backlog_reg;
        count_next   = count_reg;
        ovf_next     = ovf_reg;
        sat_hit      = 1'b0;

        if (edge_vec[0]) begin
            backlog_sum = backlog_sum + SUM_ONE;
        end
        if (edge_vec[1]) begin
            backlog_sum = backlog_sum - SUM_ONE;
        end
        if (ack_accept) begin
            if (dir_reg == DIR_PINC) begin
                backlog_sum = backlog_sum - SUM_ONE;
                count_next  = count_reg + COUNT_ONE;
            end else begin
                backlog_sum = backlog_sum + SUM_ONE;
                count_next  = count_reg - COUNT_ONE;
            end
        end

        if (backlog_sum > SAT_MAX) begin
            backlog_next = SAT_MAX[BACKLOG_W-1:0];
            sat_hit      = 1'b1;
        end else if (backlog_sum < SAT_MIN) begin
            backlog_next = SAT_MIN[BACKLOG_W-1:0];
            sat_hit      = 1'b1;
        end else begin
            backlog_next = backlog_sum[BACKLOG_W-1:0];
        end

        if (zero_i) begin
            backlog_next = '0;
            count_next   = '0;
            sat_hit      = 1'b0;
        end

        // A set in the same cycle as a clear takes precedence
        if (sat_hit) begin
            ovf_next = 1'b1;
        end else if (clear_ovf_i) begin
            ovf_next = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            dir_reg     <= DIR_PINC;
            backlog_reg <= '0;
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dir_reg     <= dir_next;
            backlog_reg <= backlog_next;
            count_reg   <= count_next;
            ovf_reg     <= ovf_next;
        end
    end

    assign inc_req_o  = (state_reg == REQ);
    assign inc_dir_o  = dir_reg;
    assign count_o    = count_reg;
    assign backlog_o  = backlog_reg;
    assign overflow_o = ovf_reg;

`ifdef CDU_PULSE_STATS_EN
    logic [15:0] plus_total_reg;
    logic [15:0] minus_total_reg;
    logic [15:0] runt_total_reg;

    // Event totals: wrap freely, cleared only by rst, both lines feed the runt total
    always_ff @(posedge clk) begin
        if (rst) begin
            plus_total_reg  <= '0;
            minus_total_reg <= '0;
            runt_total_reg  <= '0;
        end else begin
            plus_total_reg  <= plus_total_reg  + {15'd0, edge_vec[0]};
            minus_total_reg <= minus_total_reg + {15'd0, edge_vec[1]};
            runt_total_reg  <= runt_total_reg  + {15'd0, runt_vec[0]} + {15'd0, runt_vec[1]};
        end
    end

    assign plus_total_o  = plus_total_reg;
    assign minus_total_o = minus_total_reg;
    assign runt_total_o  = runt_total_reg;
`endif

endmodule

// File: tb/tb_cdu_pulse_counter_if.sv
// tb_cdu_pulse_counter_if: directed and randomized checks of the CDU pulse
// counter interface. Build with CDU_PULSE_STATS_EN to also check the totals.
module tb_cdu_pulse_counter_if;

    localparam int MINP = 2;

    logic        clk;
    logic        rst;
    logic        plus_pulse_i;
    logic        minus_pulse_i;
    logic        zero_i;
    logic        inc_ack_i;
    logic        clear_ovf_i;
    logic        inc_req_o;
    logic        inc_dir_o;
    logic [14:0] count_o;
    logic [5:0]  backlog_o;
    logic        overflow_o;
`ifdef CDU_PULSE_STATS_EN
    logic [15:0] plus_total_o;
    logic [15:0] minus_total_o;
    logic [15:0] runt_total_o;
`endif

    cdu_pulse_counter_if #(
        .MIN_PULSE_CYCLES (MINP),
        .BACKLOG_W        (6),
        .COUNT_W          (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .plus_pulse_i  (plus_pulse_i),
        .minus_pulse_i (minus_pulse_i),
        .zero_i        (zero_i),
        .inc_ack_i     (inc_ack_i),
        .inc_req_o     (inc_req_o),
        .inc_dir_o     (inc_dir_o),
        .count_o       (count_o),
        .backlog_o     (backlog_o),
        .overflow_o    (overflow_o),
`ifdef CDU_PULSE_STATS_EN
        .plus_total_o  (plus_total_o),
        .minus_total_o (minus_total_o),
        .runt_total_o  (runt_total_o),
`endif
        .clear_ovf_i   (clear_ovf_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_pinc = 0;
    int          n_minc = 0;
    int          req_age = 0;
    int          first_req_edge = -1;
    int          ack_dly = 1;
    bit          auto_ack = 1'b0;
    bit          saw_bl_nz = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_dir = 1'b0;
    logic [14:0] hs_count = '0;
    int          exp_plus = 0;
    int          exp_minus = 0;
    int          exp_runt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: track handshakes at protocol level, check the counter against
    // the serviced handshakes, then decide the ack for the next edge.
    task automatic tick();
        logic acc;
        logic was_rst;
        logic was_zero;
        int   edge_no;
        acc      = inc_ack_i && prev_req;
        was_rst  = rst;
        was_zero = zero_i;
        @(posedge clk);
        #1;
        edge_no = cyc;
        cyc++;
        if (was_rst || was_zero)
            hs_count = '0;
        else if (acc)
            hs_count = prev_dir ? hs_count - 15'd1 : hs_count + 15'd1;
        check("count_vs_handshakes", {17'd0, count_o}, {17'd0, hs_count});
        if (inc_req_o && !prev_req) begin
            if (inc_dir_o) n_minc++; else n_pinc++;
            req_age = 0;
            if (first_req_edge < 0) first_req_edge = edge_no;
        end else if (inc_req_o) begin
            req_age++;
            check("dir_stable", {31'd0, inc_dir_o}, {31'd0, prev_dir});
        end
        if (backlog_o != 6'd0) saw_bl_nz = 1'b1;
        prev_req  = inc_req_o;
        prev_dir  = inc_dir_o;
        inc_ack_i = auto_ack && inc_req_o && (req_age + 1 >= ack_dly);
    endtask

    task automatic pulse(input bit p, input bit m, input int len, input int gap);
        plus_pulse_i  = p;
        minus_pulse_i = m;
        repeat (len) tick();
        plus_pulse_i  = 1'b0;
        minus_pulse_i = 1'b0;
        repeat (gap) tick();
        if (p) begin
            if (len >= MINP) exp_plus++; else exp_runt++;
        end
        if (m) begin
            if (len >= MINP) exp_minus++; else exp_runt++;
        end
    endtask

    task automatic wait_req(input int budget);
        int k;
        k = 0;
        while (!inc_req_o && k < budget) begin
            tick();
            k++;
        end
        check("wait_req", {31'd0, inc_req_o}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nreq0;
        int base;
        logic [14:0] exp_cnt;
        int kind;
        int len;

        rst = 1'b1; plus_pulse_i = 1'b0; minus_pulse_i = 1'b0;
        zero_i = 1'b0; inc_ack_i = 1'b0; clear_ovf_i = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_req", {31'd0, inc_req_o}, 32'd0);
        check("rst_dir", {31'd0, inc_dir_o}, 32'd0);
        check("rst_count", {17'd0, count_o}, 32'd0);
        check("rst_backlog", {26'd0, backlog_o}, 32'd0);
        check("rst_ovf", {31'd0, overflow_o}, 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Three 4-cycle plus pulses, ack two cycles after each request
        auto_ack = 1'b1; ack_dly = 2;
        t0 = cyc;
        repeat (3) pulse(1'b1, 1'b0, 4, 10);
        repeat (6) tick();
        check("latency", first_req_edge - t0, 32'd5);
        check("t1_pinc", n_pinc, 32'd3);
        check("t1_minc", n_minc, 32'd0);
        check("t1_count", {17'd0, count_o}, 32'd3);
        check("t1_backlog", {26'd0, backlog_o}, 32'd0);

        // One-cycle high is a runt
        nreq0 = n_pinc + n_minc;
        pulse(1'b1, 1'b0, 1, 15);
        check("t2_noreq", n_pinc + n_minc, nreq0);
        check("t2_count", {17'd0, count_o}, 32'd3);
`ifdef CDU_PULSE_STATS_EN
        check("t2_runt_total", {16'd0, runt_total_o}, 32'd1);
`endif

        // Simultaneous plus and minus edges cancel
        saw_bl_nz = 1'b0;
        pulse(1'b1, 1'b1, 3, 12);
        check("t3_bl_stayed0", {31'd0, saw_bl_nz}, 32'd0);
        check("t3_noreq", n_pinc + n_minc, nreq0);
        check("t3_count", {17'd0, count_o}, 32'd3);

        // PINC pending, two minus edges arrive before the ack
        auto_ack = 1'b0;
        pulse(1'b1, 1'b0, 2, 0);
        wait_req(20);
        check("t4_dir_pinc", {31'd0, inc_dir_o}, 32'd0);
        pulse(1'b0, 1'b1, 2, 3);
        pulse(1'b0, 1'b1, 2, 6);
        check("t4_bl_neg1", {26'd0, backlog_o}, 32'h3F);
        check("t4_req_held", {31'd0, inc_req_o}, 32'd1);
        check("t4_dir_held", {31'd0, inc_dir_o}, 32'd0);
        inc_ack_i = 1'b1;
        tick();
        check("t4_count_after_ack", {17'd0, count_o}, 32'd4);
        check("t4_bl_neg2", {26'd0, backlog_o}, 32'h3E);
        base = n_minc;
        auto_ack = 1'b1; ack_dly = 1;
        repeat (30) tick();
        check("t4_minc_reqs", n_minc - base, 32'd2);
        check("t4_count_final", {17'd0, count_o}, 32'd2);
        check("t4_backlog_final", {26'd0, backlog_o}, 32'd0);

        // Saturation with ack held low, then zero during REQ and overflow clear
        auto_ack = 1'b0;
        repeat (40) pulse(1'b1, 1'b0, 2, 2);
        repeat (4) tick();
        check("t5_bl_sat", {26'd0, backlog_o}, 32'd31);
        check("t5_ovf_set", {31'd0, overflow_o}, 32'd1);
        check("t5_req_pending", {31'd0, inc_req_o}, 32'd1);
        zero_i = 1'b1;
        tick();
        zero_i = 1'b0;
        check("t5_zero_req", {31'd0, inc_req_o}, 32'd0);
        check("t5_zero_count", {17'd0, count_o}, 32'd0);
        check("t5_zero_bl", {26'd0, backlog_o}, 32'd0);
        check("t5_zero_keeps_ovf", {31'd0, overflow_o}, 32'd1);
        clear_ovf_i = 1'b1;
        tick();
        clear_ovf_i = 1'b0;
        check("t5_ovf_clear", {31'd0, overflow_o}, 32'd0);
        nreq0 = n_pinc + n_minc;
        repeat (10) tick();
        check("t5_no_req_after_zero", n_pinc + n_minc, nreq0);

        // Counter wraps both ways
        auto_ack = 1'b1; ack_dly = 1;
        pulse(1'b0, 1'b1, 2, 12);
        check("t6_wrap_down", {17'd0, count_o}, 32'h7FFF);
        pulse(1'b1, 1'b0, 2, 12);
        check("t6_wrap_up", {17'd0, count_o}, 32'h0000);
        check("t6_backlog", {26'd0, backlog_o}, 32'd0);

        // Randomized pulse stream against a pulse-level net count
        ack_dly = $urandom_range(1, 3);
        exp_cnt = count_o;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 2);
            len  = $urandom_range(1, 4);
            pulse(kind != 1, kind != 0, len, $urandom_range(5, 10));
            if (len >= MINP) begin
                if (kind == 0) exp_cnt = exp_cnt + 15'd1;
                if (kind == 1) exp_cnt = exp_cnt - 15'd1;
            end
        end
        repeat (40) tick();
        check("rand_count", {17'd0, count_o}, {17'd0, exp_cnt});
        check("rand_backlog", {26'd0, backlog_o}, 32'd0);
        check("rand_ovf", {31'd0, overflow_o}, 32'd0);
        check("rand_idle", {31'd0, inc_req_o}, 32'd0);
`ifdef CDU_PULSE_STATS_EN
        check("plus_total", {16'd0, plus_total_o}, exp_plus);
        check("minus_total", {16'd0, minus_total_o}, exp_minus);
        check("runt_total", {16'd0, runt_total_o}, exp_runt);
`endif

        // Reset while a request is pending
        auto_ack = 1'b0;
        pulse(1'b1, 1'b0, 2, 0);
        wait_req(20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_req", {31'd0, inc_req_o}, 32'd0);
        check("rst_mid_count", {17'd0, count_o}, 32'd0);
        check("rst_mid_bl", {26'd0, backlog_o}, 32'd0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
